// File: rtl/sysarr_iobuf_pkg.sv
// Shared register map, STATUS bit positions and run-state encoding for the
// systolic-array I/O buffer.
package sysarr_iobuf_pkg;

  localparam logic [15:0] ADR_START  = 16'hFFF0;
  localparam logic [15:0] ADR_MAX    = 16'hFFF1;
  localparam logic [15:0] ADR_RUN    = 16'hFFF2;
  localparam logic [15:0] ADR_STATUS = 16'hFFF3;
  localparam logic [15:0] OUT_BASE   = 16'h8000;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ERR    = 2;
  localparam int ST_SAT    = 3;
  localparam int ST_SAT_PE = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sysarr_lane_buf.sv
// One lane buffer: 1W2R memory with a host port and an array port (feed or capture).
// Feed data is registered one cycle after step_i; the lane stalls while step_i is low.
module sysarr_lane_buf
  import sysarr_iobuf_pkg::*;
#(
  parameter int DW  = 16,
  parameter int ADW = 10,
  parameter bit CAP = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           host_we_i,
  input  logic [ADW-1:0] host_wadr_i,
  input  logic [DW-1:0]  host_wdat_i,
  input  logic [ADW-1:0] host_radr_i,
  output logic [DW-1:0]  host_rdat_o,
  input  logic           run_i,
  input  logic           clr_i,
  input  logic [7:0]     last_i,
  input  logic           step_i,
  input  logic [DW-1:0]  arr_wdat_i,
  output logic [DW-1:0]  arr_dat_o,
  output logic           arr_vld_o,
  output logic           cmp_o,
  output logic           fire_o
);

  logic [DW-1:0]  mem_q [2**ADW];
  logic [8:0]     cnt_q, cnt_d;
  logic [DW-1:0]  dat_q;
  logic           vld_q;
  logic [ADW-1:0] ptr;
  logic           fire;

  // Counter is 9 bits so 256 entries can complete; the address wraps at depth.
  assign ptr    = ADW'(cnt_q);
  assign cmp_o  = (cnt_q == ({1'b0, last_i} + 9'd1));
  assign fire   = run_i & step_i & ~cmp_o;
  assign fire_o = fire;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (fire) cnt_d = cnt_q + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (CAP && fire)    mem_q[ptr]         <= arr_wdat_i;
    else if (host_we_i) mem_q[host_wadr_i] <= host_wdat_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= fire & ~CAP;
      if (fire && !CAP) dat_q <= mem_q[ptr];
    end
  end

  assign host_rdat_o = mem_q[host_radr_i];
  assign arr_dat_o   = dat_q;
  assign arr_vld_o   = vld_q;

endmodule

// File: rtl/sysarr_iobuf.sv
// Host-bus I/O buffers and IDLE/RUN/DONE run controller for the systolic array; host reads 1 cycle.
// Feed lanes advance only on a_ff/b_ff; SYSARR_IRQ_EN enables the level irq output.
module sysarr_iobuf
  import sysarr_iobuf_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int ADW  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ren,
  input  logic [15:0]              ibus_radr,
  output logic [DW-1:0]            ibus_rdata,
  input  logic                     wen,
  input  logic [15:0]              ibus_wadr,
  input  logic [15:0]              ibus_wdata,
  output logic                     start,
  output logic [7:0]               max_cntr,
  input  logic [ROWS-1:0]          a_ff,
  input  logic [COLS-1:0]          b_ff,
  output logic [ROWS*DW-1:0]       a_in,
  output logic [COLS*DW-1:0]       b_in,
  output logic [ROWS-1:0]          awe,
  output logic [COLS-1:0]          bwe,
  input  logic [ROWS*COLS*DW-1:0]  s_out,
  input  logic [ROWS*COLS-1:0]     sat,
  input  logic [ROWS*COLS-1:0]     sw,
  output logic                     irq
);

  localparam int NIN = ROWS + COLS;
  localparam int NPE = ROWS * COLS;

  state_e          state_q, state_d;
  logic            start_q, err_q, err_d;
  logic [7:0]      max_q, run_q;
  logic [NPE-1:0]  sat_q, sat_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            running, go, clr_st, bad;
  logic [31:0]     w_idx, r_idx;
  logic            w_in, w_out, r_in, r_out, in_we, out_we;
  logic [15:0]     status;
  logic [NIN-1:0]  in_vld, in_cmp, in_fire;
  logic [NPE-1:0]  cap_vld, cap_cmp, cap_fire;
  logic [NIN-1:0]  ff_all;
  logic [DW-1:0]   in_rd  [NIN];
  logic [DW-1:0]   cap_rd [NPE];

  assign running = (state_q == S_RUN);
  assign ff_all  = {b_ff, a_ff};

  // Lane index is the address above the per-buffer offset; 0x8000 selects the output bank.
  always_comb begin
    w_idx  = 32'(ibus_wadr[14:0]) >> ADW;
    r_idx  = 32'(ibus_radr[14:0]) >> ADW;
    w_in   = ~ibus_wadr[15] && (w_idx < 32'(NIN));
    w_out  = ibus_wadr[15] && (w_idx < 32'(NPE));
    r_in   = ~ibus_radr[15] && (r_idx < 32'(NIN));
    r_out  = ibus_radr[15] && (r_idx < 32'(NPE));
    go     = wen && (ibus_wadr == ADR_START) && !running;
    clr_st = wen && (ibus_wadr == ADR_STATUS);
    bad    = wen && running && ((ibus_wadr == ADR_START) || w_in || w_out);
    in_we  = wen && w_in && !running;
    out_we = wen && w_out && !running;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (&in_cmp && &cap_cmp) state_d = S_DONE;
      S_DONE:  if (go) state_d = S_RUN;
               else if (clr_st) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = bad ? 1'b1 : (clr_st ? 1'b0 : err_q);
    sat_d = ((clr_st || go) ? '0 : sat_q) | (cap_fire & sat);
  end

  always_comb begin
    status              = '0;
    status[ST_BUSY]     = running;
    status[ST_DONE]     = (state_q == S_DONE);
    status[ST_ERR]      = err_q;
    status[ST_SAT]      = |sat_q;
    status[15:ST_SAT_PE] = 8'(sat_q);
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = '0;
      if (ibus_radr == ADR_MAX)    rdata_d = DW'(max_q);
      if (ibus_radr == ADR_RUN)    rdata_d = DW'(run_q);
      if (ibus_radr == ADR_STATUS) rdata_d = DW'(status);
      for (int i = 0; i < NIN; i++)
        if (r_in && r_idx == 32'(i)) rdata_d = in_rd[i];
      for (int k = 0; k < NPE; k++)
        if (r_out && r_idx == 32'(k)) rdata_d = cap_rd[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= '0;
      max_q   <= '0;
      run_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= go;
      err_q   <= err_d;
      sat_q   <= sat_d;
      rdata_q <= rdata_d;
      if (wen && ibus_wadr == ADR_MAX) max_q <= ibus_wdata[7:0];
      if (wen && ibus_wadr == ADR_RUN) run_q <= ibus_wdata[7:0];
    end
  end

  for (genvar i = 0; i < NIN; i++) begin : g_in
    logic [DW-1:0] dat;
    sysarr_lane_buf #(.DW(DW), .ADW(ADW), .CAP(1'b0)) u_lane (
      .clk(clk), .rst_n(rst_n),
      .host_we_i(in_we && (w_idx == 32'(i))), .host_wadr_i(ibus_wadr[ADW-1:0]),
      .host_wdat_i(DW'(ibus_wdata)), .host_radr_i(ibus_radr[ADW-1:0]), .host_rdat_o(in_rd[i]),
      .run_i(running), .clr_i(go), .last_i(max_q), .step_i(ff_all[i]), .arr_wdat_i('0),
      .arr_dat_o(dat), .arr_vld_o(in_vld[i]), .cmp_o(in_cmp[i]), .fire_o(in_fire[i])
    );
    if (i < ROWS) begin : g_a
      assign a_in[i*DW +: DW] = dat;
    end else begin : g_b
      assign b_in[(i-ROWS)*DW +: DW] = dat;
    end
  end

  for (genvar k = 0; k < NPE; k++) begin : g_cap
    logic [DW-1:0] dat;
    sysarr_lane_buf #(.DW(DW), .ADW(ADW), .CAP(1'b1)) u_lane (
      .clk(clk), .rst_n(rst_n),
      .host_we_i(out_we && (w_idx == 32'(k))), .host_wadr_i(ibus_wadr[ADW-1:0]),
      .host_wdat_i(DW'(ibus_wdata)), .host_radr_i(ibus_radr[ADW-1:0]), .host_rdat_o(cap_rd[k]),
      .run_i(running), .clr_i(go), .last_i(run_q), .step_i(sw[k]), .arr_wdat_i(s_out[k*DW +: DW]),
      .arr_dat_o(dat), .arr_vld_o(cap_vld[k]), .cmp_o(cap_cmp[k]), .fire_o(cap_fire[k])
    );
  end

  assign awe        = in_vld[ROWS-1:0];
  assign bwe        = in_vld[NIN-1:ROWS];
  assign start      = start_q;
  assign max_cntr   = max_q;
  assign ibus_rdata = rdata_q;

`ifdef SYSARR_IRQ_EN
  assign irq = (state_q == S_DONE);
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sysarr_iobuf.sv
// Directed bench for sysarr_iobuf: host-access vector table plus run, capture, error and reset sequences.
module tb_sysarr_iobuf;

  localparam int DW = 16, ROWS = 2, COLS = 2, ADW = 10, NPE = ROWS * COLS;
`ifdef SYSARR_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, ren = 1'b0, wen = 1'b0;
  logic [15:0] ibus_radr = '0, ibus_wadr = '0, ibus_wdata = '0;
  logic [DW-1:0] ibus_rdata;
  logic start, irq;
  logic [7:0] max_cntr;
  logic [ROWS-1:0] a_ff = '0, awe;
  logic [COLS-1:0] b_ff = '0, bwe;
  logic [ROWS*DW-1:0] a_in;
  logic [COLS*DW-1:0] b_in;
  logic [NPE*DW-1:0] s_out = '0;
  logic [NPE-1:0] sat = '0, sw = '0;

  int n_chk = 0, n_fail = 0, n_start = 0;

  typedef struct {
    bit          wr;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  logic [15:0] ea [3]  = '{16'd1, 16'd2, 16'd3};
  logic [15:0] eb [3]  = '{16'd4, 16'd5, 16'd6};
  bit          ffs [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] ea2 [6] = '{16'd1, 16'd0, 16'd2, 16'd0, 16'd3, 16'd0};

  sysarr_iobuf #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .ADW(ADW)) dut (
    .clk(clk), .rst_n(rst_n), .ren(ren), .ibus_radr(ibus_radr), .ibus_rdata(ibus_rdata),
    .wen(wen), .ibus_wadr(ibus_wadr), .ibus_wdata(ibus_wdata), .start(start),
    .max_cntr(max_cntr), .a_ff(a_ff), .b_ff(b_ff), .a_in(a_in), .b_in(b_in),
    .awe(awe), .bwe(bwe), .s_out(s_out), .sat(sat), .sw(sw), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start === 1'b1) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic hwrite(input logic [15:0] a, input logic [15:0] d);
    wen = 1'b1; ibus_wadr = a; ibus_wdata = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic hread(input logic [15:0] a, output logic [15:0] d);
    ren = 1'b1; ibus_radr = a;
    tick();
    ren = 1'b0;
    d = ibus_rdata;
  endtask

  task automatic rchk(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v;
    hread(a, v);
    chk(nm, 32'(v), 32'(exp));
  endtask

  initial begin
    tbl.push_back('{1'b1, 16'h0000, 16'h0001, 16'h0000});
    tbl.push_back('{1'b1, 16'h0001, 16'h0002, 16'h0000});
    tbl.push_back('{1'b1, 16'h0002, 16'h0003, 16'h0000});
    tbl.push_back('{1'b1, 16'h0003, 16'h0007, 16'h0000});
    tbl.push_back('{1'b1, 16'h0800, 16'h0004, 16'h0000});
    tbl.push_back('{1'b1, 16'h0801, 16'h0005, 16'h0000});
    tbl.push_back('{1'b1, 16'h0802, 16'h0006, 16'h0000});
    tbl.push_back('{1'b1, 16'h8002, 16'h5555, 16'h0000});
    tbl.push_back('{1'b1, 16'h8000, 16'h1234, 16'h0000});
    tbl.push_back('{1'b1, 16'hFFF1, 16'h01A2, 16'h0000});
    tbl.push_back('{1'b1, 16'hFFF2, 16'h0001, 16'h0000});
    tbl.push_back('{1'b0, 16'h0001, 16'h0000, 16'h0002});
    tbl.push_back('{1'b0, 16'h0802, 16'h0000, 16'h0006});
    tbl.push_back('{1'b0, 16'h8002, 16'h0000, 16'h5555});
    tbl.push_back('{1'b0, 16'hFFF1, 16'h0000, 16'h00A2});
    tbl.push_back('{1'b0, 16'hFFF2, 16'h0000, 16'h0001});
    tbl.push_back('{1'b0, 16'hFFF3, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 16'hFFF0, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 16'h1000, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 16'h9000, 16'h0000, 16'h0000});
    tbl.push_back('{1'b0, 16'hFFF4, 16'h0000, 16'h0000});
    tbl.push_back('{1'b1, 16'hFFF1, 16'h0002, 16'h0000});
    tbl.push_back('{1'b0, 16'hFFF1, 16'h0000, 16'h0002});

    // Reset state
    tick(); tick();
    chk("rst start", 32'(start), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst awe_bwe", 32'({awe, bwe}), 32'd0);
    chk("rst a_in", 32'(a_in), 32'd0);
    chk("rst max_cntr", 32'(max_cntr), 32'd0);
    chk("rst rdata", 32'(ibus_rdata), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) hwrite(tbl[i].adr, tbl[i].dat);
      else rchk($sformatf("vec%0d rd %h", i, tbl[i].adr), tbl[i].adr, tbl[i].exp);
    end

    // Read data holds while ren is low
    ibus_radr = 16'h0000;
    tick();
    chk("rdata hold", 32'(ibus_rdata), 32'h0002);

    // sw outside RUN is ignored
    sw = 4'b0001; s_out[15:0] = 16'h9999;
    tick();
    sw = '0;
    rchk("idle sw ignored", 16'h8000, 16'h1234);

    // Run 1: full feed, captures, illegal writes, completion
    a_ff = 2'b11; b_ff = 2'b11;
    hwrite(16'hFFF0, 16'h0000);
    chk("start pulse", 32'(start), 32'd1);
    chk("max_cntr out", 32'(max_cntr), 32'd2);
    for (int e = 0; e < 3; e++) begin
      tick();
      if (e == 0) chk("start one cycle", 32'(start), 32'd0);
      chk($sformatf("feed%0d awe0", e), 32'(awe[0]), 32'd1);
      chk($sformatf("feed%0d a_in0", e), 32'(a_in[15:0]), 32'(ea[e]));
      chk($sformatf("feed%0d bwe0", e), 32'(bwe[0]), 32'd1);
      chk($sformatf("feed%0d b_in0", e), 32'(b_in[15:0]), 32'(eb[e]));
    end
    tick();
    chk("feed complete", 32'({awe, bwe}), 32'd0);
    hwrite(16'hFFF0, 16'h0000);
    chk("start ignored in run", 32'(start), 32'd0);
    hwrite(16'h0000, 16'hBEEF);
    sw = 4'hF; sat = 4'b1000;
    s_out = {16'h0303, 16'h0202, 16'h0101, 16'h0011};
    tick();
    sat = 4'b0000;
    s_out = {16'h0304, 16'h0203, 16'h0102, 16'h0022};
    tick();
    chk("irq before done", 32'(irq), 32'd0);
    sw = 4'b0001; sat = 4'b0001; s_out[15:0] = 16'h0033;
    tick();
    sw = '0; sat = '0;
    chk("irq at done", 32'(irq), 32'(IRQ_ON));
    rchk("status done", 16'hFFF3, 16'h080E);
    rchk("cap 8000", 16'h8000, 16'h0011);
    rchk("cap 8001", 16'h8001, 16'h0022);
    rchk("cap third ignored", 16'h8002, 16'h5555);
    rchk("cap 8C00", 16'h8C00, 16'h0303);
    rchk("cap 8C01", 16'h8C01, 16'h0304);
    rchk("run write dropped", 16'h0000, 16'h0001);
    chk("start count run1", 32'(n_start), 32'd1);
    hwrite(16'hFFF3, 16'h0000);
    chk("irq cleared", 32'(irq), 32'd0);
    rchk("status cleared", 16'hFFF3, 16'h0000);

    // Run 2: a_ff toggling, then reset mid-run
    hwrite(16'hFFF1, 16'h0003);
    a_ff = 2'b00; b_ff = 2'b11;
    hwrite(16'hFFF0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      a_ff = {2{ffs[i]}};
      tick();
      chk($sformatf("toggle%0d awe0", i), 32'(awe[0]), 32'(ffs[i]));
      if (ffs[i]) chk($sformatf("toggle%0d a_in0", i), 32'(a_in[15:0]), 32'(ea2[i]));
    end
    a_ff = 2'b11; rst_n = 1'b0;
    tick();
    chk("midrun rst awe", 32'(awe), 32'd0);
    chk("midrun rst bwe", 32'(bwe), 32'd0);
    chk("midrun rst irq", 32'(irq), 32'd0);
    chk("midrun rst max_cntr", 32'(max_cntr), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("start count run2", 32'(n_start), 32'd2);
    rchk("status after rst", 16'hFFF3, 16'h0000);
    rchk("buf kept A0[0]", 16'h0000, 16'h0001);
    rchk("buf kept A0[3]", 16'h0003, 16'h0007);
    rchk("max after rst", 16'hFFF1, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
